// File: rtl/multi_operand_adder_pipe.sv
// rtl/multi_operand_adder_pipe.sv - pipelined N-operand unsigned adder: carry-save stage then registered carry-propagate stage
// Optional build macro MOA_SATURATE_EN clamps out_sum to WIDTH bits of all-ones on overflow.
module multi_operand_adder_pipe #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 3,
    localparam int SUM_W  = WIDTH + $clog2(NUM_OPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic                     in_cin,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [SUM_W-1:0]         out_sum,
    output logic                     out_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    logic             s1_valid;
    logic             s2_valid;
    logic [SUM_W-1:0] s1_sum;
    logic [SUM_W-1:0] s1_carry;
    logic [SUM_W-1:0] csa_sum;
    logic [SUM_W-1:0] csa_carry;
    logic [SUM_W-1:0] csa_tmp;
    logic [SUM_W-1:0] op_row;
    logic [SUM_W-1:0] cpa;
    logic             cpa_ovf;
    logic [SUM_W-1:0] s2_result;
    logic             s2_adv;
    logic             s1_adv;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

    // Carry-in rides as a row of its own; each 3:2 step folds one more operand in.
    // The carry shift may drop its MSB: the true sum always fits SUM_W, so mod-2^SUM_W is exact.
    always_comb begin
        csa_sum   = SUM_W'(in_ops[WIDTH-1:0]);
        csa_carry = SUM_W'(in_cin);
        csa_tmp   = '0;
        op_row    = '0;
        for (int k = 1; k < NUM_OPS; k++) begin
            op_row    = SUM_W'(in_ops[k*WIDTH +: WIDTH]);
            csa_tmp   = csa_sum ^ csa_carry ^ op_row;
            csa_carry = ((csa_sum & csa_carry) | (csa_sum & op_row) | (csa_carry & op_row)) << 1;
            csa_sum   = csa_tmp;
        end
    end

    always_comb begin
        cpa     = s1_sum + s1_carry;
        cpa_ovf = |cpa[SUM_W-1:WIDTH];
`ifdef MOA_SATURATE_EN
        s2_result = cpa_ovf ? SUM_W'({WIDTH{1'b1}}) : cpa;
`else
        s2_result = cpa;
`endif
    end

    // Data registers load only with a valid token so stray X on idle inputs never reaches out_sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            out_sum  <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_sum <= s2_result;
                    out_ovf <= cpa_ovf;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sum   <= csa_sum;
                    s1_carry <= csa_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// tb/tb_multi_operand_adder_pipe.sv - scoreboard bench for multi_operand_adder_pipe
module tb_multi_operand_adder_pipe;

    typedef struct {
        logic [23:0] ops;
        logic        cin;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_ops;
    logic        in_cin;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  out_sum;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [31:0] w_ops;
    logic        w_cin;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  w_sum;
    logic        w_ovf;
    logic        w_out_valid;
    logic        w_out_ready;
    logic        w_busy;

    stim_t       stim_q[$];
    logic [10:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          run = 0;
    int          max_run = 0;
    int          last_acc = 0;
    int          last_out = 0;
    logic        have_hold = 1'b0;
    logic [10:0] held;

    multi_operand_adder_pipe #(.WIDTH(8), .NUM_OPS(3)) u_dut (
        .clk(clk), .rst(rst), .in_ops(in_ops), .in_cin(in_cin),
        .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    multi_operand_adder_pipe #(.WIDTH(4), .NUM_OPS(8)) u_dut_wide (
        .clk(clk), .rst(rst), .in_ops(w_ops), .in_cin(w_cin),
        .in_valid(w_valid), .in_ready(w_ready), .out_sum(w_sum),
        .out_ovf(w_ovf), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .busy(w_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] model(input logic [23:0] ops, input logic cin);
        int   s;
        logic ovf;
        s = int'(cin);
        for (int k = 0; k < 3; k++) s += int'(ops[k*8 +: 8]);
        ovf = (s > 255);
`ifdef MOA_SATURATE_EN
        if (ovf) s = 255;
`endif
        return {ovf, 10'(s)};
    endfunction

    task automatic push_stim(input logic [23:0] ops, input logic cin);
        stim_t s;
        s.ops = ops;
        s.cin = cin;
        stim_q.push_back(s);
    endtask

    // One cycle: drive at negedge, then observe the handshakes that the next posedge will commit.
    task automatic tick(input logic ordy);
        logic [10:0] e;
        @(negedge clk);
        out_ready = ordy;
        if (stim_q.size() > 0) begin
            in_valid = 1'b1;
            in_ops   = stim_q[0].ops;
            in_cin   = stim_q[0].cin;
        end else begin
            in_valid = 1'b0;
            in_ops   = 24'($urandom());
            in_cin   = 1'b0;
        end
        #1;
        cyc++;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_ops, in_cin));
            stim_q.delete(0);
            n_acc++;
            last_acc = cyc;
        end
        if (have_hold) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_sum", 32'(out_sum), 32'(held[9:0]));
            check_eq("hold_ovf", 32'(out_ovf), 32'(held[10]));
            have_hold = 1'b0;
        end
        if (out_valid) begin
            run++;
            n_out++;
            if (run > max_run) max_run = run;
            if (out_ready) begin
                check_eq("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sum", 32'(out_sum), 32'(e[9:0]));
                    check_eq("ovf", 32'(out_ovf), 32'(e[10]));
                end
                last_out = cyc;
            end else begin
                held      = {out_ovf, out_sum};
                have_hold = 1'b1;
            end
        end else begin
            run = 0;
        end
    endtask

    initial begin
        int   n0;
        logic found;
        rst = 1'b1; in_ops = '0; in_cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        w_ops = '0; w_cin = 1'b0; w_valid = 1'b0; w_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
        check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Directed small sum: single pulse, two-cycle latency
        n0 = n_out;
        push_stim(24'h030201, 1'b0);
        repeat (5) tick(1'b1);
        check_eq("single_pulse", 32'(n_out - n0), 32'd1);
        check_eq("latency", 32'(last_out - last_acc), 32'd2);

        push_stim(24'hFFFFFF, 1'b1);
        repeat (4) tick(1'b1);

        // 16 back-to-back random sets
        max_run = 0;
        for (int i = 0; i < 16; i++) push_stim(24'($urandom()), 1'($urandom_range(0, 1)));
        repeat (20) tick(1'b1);
        check_eq("b2b_run", 32'(max_run), 32'd16);
        check_eq("b2b_drained", 32'(exp_q.size() + stim_q.size()), 32'd0);

        // Backpressure for 5 cycles while streaming
        n_acc = 0;
        for (int i = 0; i < 8; i++) push_stim(24'($urandom()), 1'($urandom_range(0, 1)));
        repeat (5) tick(1'b0);
        check_eq("bp_accepts", 32'(n_acc), 32'd2);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_busy", 32'(busy), 32'd1);
        repeat (12) tick(1'b1);
        check_eq("bp_drained", 32'(exp_q.size() + stim_q.size()), 32'd0);

        // One-cycle out_ready toggle
        for (int i = 0; i < 12; i++) push_stim(24'($urandom()), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 40; i++) tick(1'(i % 2));
        check_eq("tog_drained", 32'(exp_q.size() + stim_q.size()), 32'd0);

        // Reset one cycle after an accept discards the in-flight result
        push_stim(24'h302010, 1'b0);
        tick(1'b1);
        check_eq("rstm_accept", 32'(exp_q.size()), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        have_hold = 1'b0;
        run = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rstm_out_valid", 32'(out_valid), 32'd0);
        check_eq("rstm_out_sum", 32'(out_sum), 32'd0);
        check_eq("rstm_out_ovf", 32'(out_ovf), 32'd0);
        check_eq("rstm_busy", 32'(busy), 32'd0);
        check_eq("rstm_in_ready", 32'(in_ready), 32'd1);
        n0 = n_out;
        repeat (4) tick(1'b1);
        check_eq("rstm_no_pulse", 32'(n_out - n0), 32'd0);

        // Wide configuration: eight 4-bit operands
        @(negedge clk);
        w_valid = 1'b1; w_ops = 32'hFFFF_FFFF; w_cin = 1'b1;
        #1;
        check_eq("wide_in_ready", 32'(w_ready), 32'd1);
        @(negedge clk);
        w_valid = 1'b0; w_ops = $urandom(); w_cin = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (w_out_valid) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("wide_out_valid", 32'(found), 32'd1);
`ifdef MOA_SATURATE_EN
        check_eq("wide_sum", 32'(w_sum), 32'h0F);
`else
        check_eq("wide_sum", 32'(w_sum), 32'h79);
`endif
        check_eq("wide_ovf", 32'(w_ovf), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
